// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Video mode descriptors and axis-length helper for vga_timing_gen.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_disp;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_disp;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480_60 = '{
    h_disp: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_disp: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    h_pol:  1'b0, v_pol: 1'b0
  };

  localparam vga_mode_t SVGA_800x600_60 = '{
    h_disp: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_disp: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol:  1'b1, v_pol: 1'b1
  };

  function automatic int unsigned axis_total(
    input int unsigned disp,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return disp + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_timing
// Brief    : One video axis: position counter with registered sync/active flags.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int DISP = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter bit POL  = 1'b0,
  parameter int CW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active
);

  localparam int unsigned   c_total      = axis_total(DISP, FP, SYNC, BP);
  localparam logic [CW-1:0] c_last       = CW'(c_total - 1);
  localparam logic [CW-1:0] c_disp       = CW'(DISP);
  localparam logic [CW-1:0] c_sync_start = CW'(DISP + FP);
  localparam logic [CW-1:0] c_sync_end   = CW'(DISP + FP + SYNC);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;
  logic          w_wrap;
  logic          w_sync_next;
  logic          r_sync;
  logic          r_active;

  assign w_wrap      = (r_count == c_last);
  assign w_next      = w_wrap ? '0 : r_count + 1'b1;
  assign w_sync_next = ((w_next >= c_sync_start) && (w_next < c_sync_end)) ? POL : ~POL;

  // Flags decode the upcoming count so they change on the same edge as the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_sync   <= ~POL;
      r_active <= 1'b1;
    end else if (advance) begin
      r_count  <= w_next;
      r_sync   <= w_sync_next;
      r_active <= (w_next < c_disp);
    end
  end

  assign count  = r_count;
  assign wrap   = w_wrap;
  assign sync   = r_sync;
  assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing generator with pixel divider and strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = int'(VGA_640x480_60.h_disp),
  parameter int H_FP    = int'(VGA_640x480_60.h_fp),
  parameter int H_SYNC  = int'(VGA_640x480_60.h_sync),
  parameter int H_BP    = int'(VGA_640x480_60.h_bp),
  parameter int V_DISP  = int'(VGA_640x480_60.v_disp),
  parameter int V_FP    = int'(VGA_640x480_60.v_fp),
  parameter int V_SYNC  = int'(VGA_640x480_60.v_sync),
  parameter int V_BP    = int'(VGA_640x480_60.v_bp),
  parameter bit HS_POL  = VGA_640x480_60.h_pol,
  parameter bit VS_POL  = VGA_640x480_60.v_pol,
  parameter int CW      = 10,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               p_tick,
  output logic [CW-1:0]      pixel_x,
  output logic [CW-1:0]      pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned c_h_total = axis_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int unsigned c_v_total = axis_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam int          c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  generate
    if ((longint'(c_h_total) - 1) >= (longint'(1) << CW)) begin : g_chk_h_width
      $fatal(1, "vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if ((longint'(c_v_total) - 1) >= (longint'(1) << CW)) begin : g_chk_v_width
      $fatal(1, "vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end
    if (CLK_DIV < 1) begin : g_chk_div
      $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
    end
  endgenerate

  logic [c_div_w-1:0] r_div;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               w_tick;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_h_active;
  logic               w_v_active;
  logic               w_h_sync;
  logic               w_v_sync;
  logic [CW-1:0]      w_x;
  logic [CW-1:0]      w_y;

  // Reset gating keeps the tick low during reset even when CLK_DIV is 1.
  assign w_tick = en && !reset && (r_div == c_div_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
    end
  end

  vga_axis_timing #(
    .DISP (H_DISP),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .POL  (HS_POL),
    .CW   (CW)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .advance (w_tick),
    .count   (w_x),
    .wrap    (w_h_wrap),
    .sync    (w_h_sync),
    .active  (w_h_active)
  );

  vga_axis_timing #(
    .DISP (V_DISP),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .POL  (VS_POL),
    .CW   (CW)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .advance (w_tick && w_h_wrap),
    .count   (w_y),
    .wrap    (w_v_wrap),
    .sync    (w_v_sync),
    .active  (w_v_active)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign p_tick      = w_tick;
  assign pixel_x     = w_x;
  assign pixel_y     = w_y;
  assign hsync       = w_h_sync;
  assign vsync       = w_v_sync;
  assign video_on    = w_h_active && w_v_active;
  assign line_start  = w_tick && (w_x == '0);
  assign frame_start = w_tick && (w_x == '0) && (w_y == '0);
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen, two modes driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // Mode A: divided pixel clock, mixed polarities.
  localparam int A_D = 3, A_HD = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VD = 5, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam bit A_HP = 1'b0, A_VP = 1'b1;
  localparam int A_CW = 5, A_FW = 3;
  // Mode B: undivided clock, positive syncs.
  localparam int B_D = 1, B_HD = 8, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VD = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam bit B_HP = 1'b1, B_VP = 1'b1;
  localparam int B_CW = 4, B_FW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;

  logic            a_tick, a_hs, a_vs, a_vid, a_ls, a_fs;
  logic [A_CW-1:0] a_x, a_y;
  logic [A_FW-1:0] a_f;
  logic            b_tick, b_hs, b_vs, b_vid, b_ls, b_fs;
  logic [B_CW-1:0] b_x, b_y;
  logic [B_FW-1:0] b_f;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(A_D), .H_DISP(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_DISP(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(A_HP), .VS_POL(A_VP), .CW(A_CW), .FRAME_W(A_FW)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .p_tick(a_tick),
    .pixel_x(a_x), .pixel_y(a_y), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vid), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_f)
  );

  vga_timing_gen #(
    .CLK_DIV(B_D), .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(B_HP), .VS_POL(B_VP), .CW(B_CW), .FRAME_W(B_FW)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .p_tick(b_tick),
    .pixel_x(b_x), .pixel_y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vid), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_f)
  );

  typedef struct {
    bit tick; bit ls; bit fs; bit hs; bit vs; bit vid;
    int x; int y; int f;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  int   checks = 0;
  int   errors = 0;
  longint e_cnt = 0;  // enabled clocks since reset release

  // Reference: position follows from the number of pixel ticks so far.
  function automatic obs_t model(input int d, input int hd, input int hf, input int hs,
                                 input int hb, input int vd, input int vf, input int vs,
                                 input int vb, input bit hp, input bit vp, input int fw,
                                 input longint ecnt, input bit en_v, input bit rs);
    obs_t   r;
    longint ht, vt, t;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (rs) begin
      r.tick = 0; r.ls = 0; r.fs = 0; r.x = 0; r.y = 0; r.f = 0;
      r.hs = !hp; r.vs = !vp; r.vid = 1;
      return r;
    end
    t      = ecnt / d;
    r.x    = int'(t % ht);
    r.y    = int'((t / ht) % vt);
    r.f    = int'((t / (ht * vt)) % (longint'(1) << fw));
    r.tick = en_v && ((ecnt % d) == longint'(d - 1));
    r.ls   = r.tick && (r.x == 0);
    r.fs   = r.ls && (r.y == 0);
    r.vid  = (r.x < hd) && (r.y < vd);
    r.hs   = (r.x >= hd + hf && r.x < hd + hf + hs) ? hp : !hp;
    r.vs   = (r.y >= vd + vf && r.y < vd + vf + vs) ? vp : !vp;
    return r;
  endfunction

  task automatic compare(input string nm, input obs_t e, input obs_t g);
    checks++;
    if (e.tick != g.tick || e.ls != g.ls || e.fs != g.fs || e.hs != g.hs ||
        e.vs != g.vs || e.vid != g.vid || e.x != g.x || e.y != g.y || e.f != g.f) begin
      errors++;
      $display("FAIL %s @%0t: got tick=%0d ls=%0d fs=%0d x=%0d y=%0d f=%0d hs=%0d vs=%0d vid=%0d, expected tick=%0d ls=%0d fs=%0d x=%0d y=%0d f=%0d hs=%0d vs=%0d vid=%0d",
               nm, $time, g.tick, g.ls, g.fs, g.x, g.y, g.f, g.hs, g.vs, g.vid,
               e.tick, e.ls, e.fs, e.x, e.y, e.f, e.hs, e.vs, e.vid);
    end
  endtask

  // Monitor: samples mid-cycle, after inputs settle and before the next edge.
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        g.tick = a_tick; g.ls = a_ls; g.fs = a_fs; g.hs = a_hs; g.vs = a_vs; g.vid = a_vid;
        g.x = int'(a_x); g.y = int'(a_y); g.f = int'(a_f);
        compare("mode_a", e, g);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        g.tick = b_tick; g.ls = b_ls; g.fs = b_fs; g.hs = b_hs; g.vs = b_vs; g.vid = b_vid;
        g.x = int'(b_x); g.y = int'(b_y); g.f = int'(b_f);
        compare("mode_b", e, g);
      end
    end
  end

  task automatic step(input bit en_v, input bit rs_v);
    @(posedge clk);
    #1;
    en    = en_v;
    reset = rs_v;
    if (rs_v) e_cnt = 0;
    qa.push_back(model(A_D, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB,
                       A_HP, A_VP, A_FW, e_cnt, en_v, rs_v));
    qb.push_back(model(B_D, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB,
                       B_HP, B_VP, B_FW, e_cnt, en_v, rs_v));
    if (!rs_v && en_v) e_cnt++;
  endtask

  initial begin
    bit r_en;
    repeat (3) step(1'b1, 1'b1);
    repeat (200) step(1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b0);
    repeat (6000) begin
      r_en = ($urandom_range(0, 9) != 0);
      step(r_en, 1'b0);
    end
    // Reset lands between edges somewhere inside a frame.
    repeat (2) step(1'b1, 1'b1);
    repeat (500) begin
      r_en = ($urandom_range(0, 4) != 0);
      step(r_en, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator, the next generation of `vga_sync`. It produces pixel-enable, sync, active-video and pixel-coordinate signals from the system clock for any mode, given the per-axis porch, sync and display lengths. New over `vga_sync`: programmable pixel-clock divide, sync polarity, a run/freeze enable, line/frame start strobes and a frame counter. It sits between the system clock and the pixel/renderer logic; downstream video blocks consume `p_tick`, `pixel_x`/`pixel_y` and `video_on`.

## Interface
Parameters:
- CLK_DIV, 4 — system clocks per pixel, ≥1
- H_DISP, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48 — horizontal lengths in pixels, each ≥1
- V_DISP, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33 — vertical lengths in lines, each ≥1
- HS_POL, 0 / VS_POL, 0 — active sync level
- CW, 10 — coordinate width
- FRAME_W, 8 — frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = run; 0 = freeze divider and counters
- p_tick  out  1  one-clk pixel enable
- pixel_x  out  CW  horizontal count, 0..H_TOTAL-1
- pixel_y  out  CW  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level HS_POL when active
- vsync  out  1  vertical sync, level VS_POL when active
- video_on  out  1  visible-area flag
- line_start  out  1  one-clk strobe at pixel_x = 0
- frame_start  out  1  one-clk strobe at (0,0)
- frame_cnt  out  FRAME_W  completed-frame count, wraps mod 2^FRAME_W

## Operation
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP. V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP.
- Elaboration check: if H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits, elaboration must fail.
- Pixel divider `div` counts 0..CLK_DIV-1 while en=1.
  - p_tick = en && div==CLK_DIV-1.
  - With CLK_DIV=1, p_tick = en.
- On each clk edge where p_tick=1:
  - pixel_x increments.
  - At H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments.
  - At V_TOTAL-1 with an x-wrap, pixel_y wraps to 0 and frame_cnt increments.
- Decoded flags, all coherent with the pixel_x/pixel_y values of the same cycle:
  - video_on = pixel_x<H_DISP && pixel_y<V_DISP.
  - hsync = HS_POL when H_DISP+H_FP ≤ pixel_x < H_DISP+H_FP+H_SYNC, else ~HS_POL.
  - vsync likewise on pixel_y with the V_* parameters and VS_POL.
- hsync, vsync and video_on are registers, not decodes. They are loaded from the next-count values on the same edge the counters update, so no combinational path exists from counter to pin.
- line_start = p_tick && pixel_x==0.
- frame_start = line_start && pixel_y==0.
- en=0:
  - div, counters and flags hold their values.
  - p_tick, line_start and frame_start are 0.
  - On en returning to 1, counting resumes from the held div value.
- Reset values (applied asynchronously):
  - div=0, pixel_x=0, pixel_y=0, frame_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - video_on=1, since (0,0) is visible.
  - p_tick, line_start and frame_start = 0.

## Timing
- After reset release with en=1, the first p_tick is in the CLK_DIV-th clk cycle (div reaches CLK_DIV-1). That p_tick also raises line_start and frame_start for the (0,0) pixel.
- Subsequent p_ticks occur every CLK_DIV clks.
- The counters and registered flags change on the clk edge that ends a p_tick cycle. Each value is stable for CLK_DIV clks.
- Line period is H_TOTAL·CLK_DIV clks; frame period is H_TOTAL·V_TOTAL·CLK_DIV clks. Defaults: 3200 and 1,680,000.
- frame_cnt increments on the same edge where pixel_x and pixel_y both wrap to 0.
- Reset asserted mid-frame forces all outputs to their reset values immediately, without waiting for a clk edge. Reset takes priority over en.

## Structure
- Package `vga_timing_pkg`:
  - A struct/constant set per mode (DISP/FP/SYNC/BP per axis, polarities).
  - Defaults VGA_640x480_60 and SVGA_800x600_60.
  - A helper function for TOTAL.
- Sub-module `vga_axis_timing`, instantiated once per axis:
  - Parameterised by DISP/FP/SYNC/BP/POL/CW.
  - Inputs: advance strobe.
  - Outputs: count, wrap, registered sync and registered active flag.
- The top level contains the divider, the frame counter, the strobes and the two axis instances.

## Test plan
- Reset held 3 clks, then released, defaults, en=1 → all outputs at reset values while reset is held. First p_tick on the 4th clk after release, with line_start=frame_start=1. Afterwards, p_tick period is 4 clks.
- Defaults, one full line → hsync=0 exactly for pixel_x 656..751 (96 pixels). video_on=0 from pixel_x=640. pixel_y goes 0→1 after 3200 clks.
- Defaults, one full frame → vsync=0 exactly for pixel_y 490..491. frame_cnt 0→1 and a frame_start pulse after 1,680,000 clks.
- en=0 for 50 clks while pixel_x=100 → p_tick, line_start and frame_start are 0; pixel_x holds 100. On en=1, pixel_x resumes at 101 after the remaining divider count.
- CLK_DIV=1; H 8/1/2/1; V 4/1/1/1; HS_POL=VS_POL=1; CW=4 → p_tick constant 1. hsync=1 at pixel_x 9..10. H_TOTAL=12, V_TOTAL=7. frame_cnt increments every 84 clks.
- Reset asserted asynchronously at (300,200) between clk edges → all outputs at reset values before the next clk edge. Counting restarts at (0,0) after release.
